encode_pk_stream: RTL and testbench

- Sequential inverse of the public-key unpacking path: latches rho and the K polynomials of t, then serialises the Kyber768 public key as a byte stream.
- Stream order per FIPS 203 ByteEncode12: t[0], t[1], t[2] (12-bit coefficients, little-endian packed), then the 32 bytes of rho; 1184 bytes total.
- Sits at the output of key generation, or at the host interface where the encapsulation input vector is produced; feeds a byte-wide valid/ready sink (UART/DMA/hash absorber).

---
 rtl/kyber_pkg.sv | 24 ++
 rtl/encode_pk_stream.sv | 104 ++++++++++
 tb/tb_encode_pk_stream.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber768 sizes, types and serialiser state encoding
//
// Purpose: constants and types common to the public-key pack/unpack path.
// Ports:   none (package).

package kyber_pkg;

   localparam int KYBER_K       = 3;
   localparam int KYBER_N       = 256;
   localparam int KYBER_R_WIDTH = 12;
   localparam int KYBER_Q       = 3329;

   localparam int POLY_BYTES = (KYBER_N * KYBER_R_WIDTH) / 8;
   localparam int PK_BYTES   = (KYBER_K * KYBER_R_WIDTH * KYBER_N + KYBER_N) / 8;

   typedef logic [KYBER_N*KYBER_R_WIDTH-1:0] poly_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } encpk_state_t;

endpackage

// File: rtl/encode_pk_stream.sv
// rtl/encode_pk_stream.sv - serialises a Kyber768 public key (t || rho) as a byte stream
//
// Purpose: on start, latch t[0..K-1] and rho, then emit the ByteEncode12 packing
//          of t followed by the 32 rho bytes, one byte per handshake.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       one-cycle request, sampled only while idle
//   rho_in      256-bit seed, byte j at [8j+:8]
//   t_in        K polynomials, coefficient i of poly k at t_in[k][12i+:12]
//   busy        high while the stream is in flight
//   m_tdata/m_tvalid/m_tready/m_tlast  byte-wide output stream
//   done        one-cycle pulse after the final byte is accepted

module encode_pk_stream
   import kyber_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [KYBER_N-1:0] rho_in,
   input  poly_t              t_in [KYBER_K],
   output logic               busy,
   output logic [7:0]         m_tdata,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               m_tlast,
   output logic               done
);

   localparam int POLY_BITS = KYBER_N * KYBER_R_WIDTH;
   localparam int SR_W      = PK_BYTES * 8;
   localparam int CNT_W     = 11;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PK_BYTES - 1);

   encpk_state_t     state_q, state_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [SR_W-1:0]  load_vec;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hs;

   // Packed 12-bit coefficients are already in ByteEncode12 bit order, so the
   // whole key is just t[0] at the LSBs, then t[1], t[2], then rho on top.
   always_comb begin
      load_vec = '0;
      for (int k = 0; k < KYBER_K; k++) begin
         load_vec[k*POLY_BITS +: POLY_BITS] = t_in[k];
      end
      load_vec[KYBER_K*POLY_BITS +: KYBER_N] = rho_in;
   end

   assign m_tvalid = (state_q == SEND);
   assign busy     = (state_q == SEND);
   assign done     = (state_q == DONE);
   assign m_tlast  = (state_q == SEND) && (cnt_q == LAST_IDX);
   assign m_tdata  = sr_q[7:0];
   assign hs       = m_tvalid && m_tready;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = load_vec;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (hs) begin
               sr_d = sr_q >> 8;
               if (cnt_q == LAST_IDX) begin
                  // Counter returns to zero here so it never passes the last index.
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_encode_pk_stream.sv
// tb/tb_encode_pk_stream.sv - self-checking bench for encode_pk_stream

module tb_encode_pk_stream;
   import kyber_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [KYBER_N-1:0] rho_in;
   poly_t              t_in [KYBER_K];
   logic               busy;
   logic [7:0]         m_tdata;
   logic               m_tvalid;
   logic               m_tready;
   logic               m_tlast;
   logic               done;

   encode_pk_stream dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rho_in   (rho_in),
      .t_in     (t_in),
      .busy     (busy),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .done     (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   poly_t              m_t [KYBER_K];
   logic [KYBER_N-1:0] m_rho;
   logic [7:0]         exp_b [PK_BYTES];
   logic [7:0]         got   [PK_BYTES];

   int got_n, tlast_cnt, tlast_bad, stall_bad, done_cnt, valid_cycles, done_gap, first_bad;
   bit timed_out;

   // Reference: ByteEncode12 written as arithmetic on coefficient values.
   function automatic void build_exp();
      for (int k = 0; k < KYBER_K; k++) begin
         for (int g = 0; g < KYBER_N/2; g++) begin
            int c0, c1;
            c0 = int'(m_t[k][24*g +: 12]);
            c1 = int'(m_t[k][24*g+12 +: 12]);
            exp_b[k*POLY_BYTES + 3*g]     = 8'(c0 % 256);
            exp_b[k*POLY_BYTES + 3*g + 1] = 8'((c1 % 16) * 16 + c0 / 256);
            exp_b[k*POLY_BYTES + 3*g + 2] = 8'(c1 / 16);
         end
      end
      for (int j = 0; j < 32; j++) exp_b[KYBER_K*POLY_BYTES + j] = m_rho[8*j +: 8];
   endfunction

   function automatic int count_bad();
      int n;
      n = 0;
      first_bad = -1;
      for (int i = 0; i < PK_BYTES; i++) begin
         if (got[i] !== exp_b[i]) begin
            if (first_bad < 0) first_bad = i;
            n++;
         end
      end
      return n;
   endfunction

   task automatic zero_model();
      for (int k = 0; k < KYBER_K; k++) m_t[k] = '0;
      m_rho = '0;
   endtask

   task automatic rand_model();
      for (int k = 0; k < KYBER_K; k++)
         for (int i = 0; i < KYBER_N; i++) m_t[k][12*i +: 12] = 12'($urandom_range(3328));
      for (int w = 0; w < 8; w++) m_rho[32*w +: 32] = $urandom;
   endtask

   task automatic apply_inputs();
      for (int k = 0; k < KYBER_K; k++) t_in[k] = m_t[k];
      rho_in = m_rho;
   endtask

   task automatic start_stream(input string name);
      @(negedge clk);
      m_tready = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (m_tvalid !== 1'b1 || busy !== 1'b1 || m_tdata !== exp_b[0]) begin
         failures++;
         $display("FAIL %s_latency: valid=%b busy=%b data=%h, required valid=1 busy=1 data=%h",
                  name, m_tvalid, busy, m_tdata, exp_b[0]);
      end
   endtask

   // Drives m_tready with the given duty, captures accepted bytes, stops on
   // done, on reaching abort_at bytes, or on the cycle budget.
   task automatic collect(input int ready_pct, input int abort_at, input bit start_mid,
                          input bit start_in_done);
      bit rdy, prev_stall, finished, prev_last;
      logic [7:0] prev_data;
      int last_cyc;
      got_n = 0; tlast_cnt = 0; tlast_bad = 0; stall_bad = 0; done_cnt = 0;
      valid_cycles = 0; done_gap = -1; last_cyc = -1;
      prev_stall = 0; finished = 0; prev_data = '0; prev_last = 0;
      for (int i = 0; i < PK_BYTES; i++) got[i] = 8'hxx;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
            stall_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            done_gap = cyc - last_cyc;
            finished = 1;
            if (start_in_done) start = 1'b1;
            break;
         end
         if (abort_at >= 0 && got_n == abort_at) begin
            finished = 1;
            break;
         end
         rdy = ($urandom_range(99) < ready_pct);
         m_tready = rdy;
         if (m_tvalid === 1'b1) valid_cycles++;
         if (m_tvalid === 1'b1 && rdy) begin
            if (got_n < PK_BYTES) got[got_n] = m_tdata;
            if (m_tlast === 1'b1) begin
               tlast_cnt++;
               if (got_n != PK_BYTES-1) tlast_bad++;
            end
            got_n++;
            last_cyc = cyc;
            prev_stall = 0;
            if (start_mid && got_n == 100) start = 1'b1;
         end else begin
            prev_stall = (m_tvalid === 1'b1);
            prev_data  = m_tdata;
            prev_last  = m_tlast;
         end
      end
      timed_out = !finished;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; m_tready = 1'b0;
      zero_model(); apply_inputs();
      repeat (3) @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: valid=%b last=%b busy=%b done=%b, required all 0",
                  m_tvalid, m_tlast, busy, done);
      end
      checks++;
      if (m_tdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_data: got %h, required 00", m_tdata);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: valid=%b busy=%b, required 0 0", m_tvalid, busy);
      end
   endtask

   task automatic test_packing();
      int nz;
      zero_model();
      m_t[0][11:0]  = 12'h123;
      m_t[0][23:12] = 12'hABC;
      build_exp(); apply_inputs();
      start_stream("packing");
      collect(100, -1, 0, 0);
      checks++;
      if (timed_out || got_n != PK_BYTES) begin
         failures++;
         $display("FAIL packing_count: got %0d bytes timeout=%0d, required %0d", got_n, timed_out, PK_BYTES);
      end
      checks++;
      if (got[0] !== 8'h23 || got[1] !== 8'hC1 || got[2] !== 8'hAB) begin
         failures++;
         $display("FAIL packing_head: got %h %h %h, required 23 C1 AB", got[0], got[1], got[2]);
      end
      nz = 0;
      for (int i = 3; i < PK_BYTES; i++) if (got[i] !== 8'h00) nz++;
      checks++;
      if (nz != 0) begin
         failures++;
         $display("FAIL packing_zero_tail: %0d nonzero bytes, required 0", nz);
      end
      checks++;
      if (tlast_cnt != 1 || tlast_bad != 0) begin
         failures++;
         $display("FAIL packing_tlast: count=%0d misplaced=%0d, required 1 and 0", tlast_cnt, tlast_bad);
      end
      checks++;
      if (valid_cycles != PK_BYTES) begin
         failures++;
         $display("FAIL packing_valid_cycles: got %0d, required %0d", valid_cycles, PK_BYTES);
      end
      checks++;
      if (done_cnt != 1 || done_gap != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL packing_done: pulses=%0d gap=%0d busy=%b, required 1 1 0", done_cnt, done_gap, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL packing_after_done: done=%b busy=%b valid=%b, required 0 0 0", done, busy, m_tvalid);
      end
   endtask

   task automatic test_rho_tail();
      int nb;
      zero_model();
      m_t[1][11:0]          = 12'hFFF;
      m_t[2][255*12 +: 12]  = 12'h800;
      for (int j = 0; j < 32; j++) m_rho[8*j +: 8] = 8'(j);
      build_exp(); apply_inputs();
      start_stream("rho");
      collect(100, -1, 0, 0);
      checks++;
      if (got[384] !== 8'hFF || got[385] !== 8'h0F) begin
         failures++;
         $display("FAIL rho_poly1_head: got %h %h, required FF 0F", got[384], got[385]);
      end
      checks++;
      if (got[1150] !== 8'h00 || got[1151] !== 8'h80) begin
         failures++;
         $display("FAIL rho_poly2_tail: got %h %h, required 00 80", got[1150], got[1151]);
      end
      nb = 0;
      for (int j = 0; j < 32; j++) if (got[1152+j] !== 8'(j)) nb++;
      checks++;
      if (nb != 0) begin
         failures++;
         $display("FAIL rho_bytes: %0d wrong, required 0 (byte 1183=%h)", nb, got[1183]);
      end
      checks++;
      if (got[1183] !== 8'h1F || tlast_cnt != 1 || tlast_bad != 0 || got_n != PK_BYTES) begin
         failures++;
         $display("FAIL rho_last: byte=%h tlast=%0d misplaced=%0d n=%0d, required 1F 1 0 %0d",
                  got[1183], tlast_cnt, tlast_bad, got_n, PK_BYTES);
      end
   endtask

   task automatic test_backpressure();
      int nb;
      rand_model(); build_exp(); apply_inputs();
      start_stream("bp");
      collect(30, -1, 0, 0);
      nb = count_bad();
      checks++;
      if (timed_out || got_n != PK_BYTES) begin
         failures++;
         $display("FAIL bp_count: got %0d timeout=%0d, required %0d", got_n, timed_out, PK_BYTES);
      end
      checks++;
      if (nb != 0) begin
         failures++;
         $display("FAIL bp_stream: %0d bytes differ, first at %0d, required 0", nb, first_bad);
      end
      checks++;
      if (stall_bad != 0) begin
         failures++;
         $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stall_bad);
      end
      checks++;
      if (tlast_cnt != 1 || tlast_bad != 0 || done_cnt != 1) begin
         failures++;
         $display("FAIL bp_end: tlast=%0d misplaced=%0d done=%0d, required 1 0 1", tlast_cnt, tlast_bad, done_cnt);
      end
   endtask

   task automatic test_start_handling();
      int nb;
      rand_model(); build_exp(); apply_inputs();
      start_stream("start");
      // Model keeps the originally sampled key; only the DUT inputs move.
      for (int k = 0; k < KYBER_K; k++)
         for (int w = 0; w < KYBER_N*KYBER_R_WIDTH/32; w++) t_in[k][32*w +: 32] = $urandom;
      for (int w = 0; w < 8; w++) rho_in[32*w +: 32] = $urandom;
      collect(70, -1, 1, 1);
      nb = count_bad();
      checks++;
      if (nb != 0 || got_n != PK_BYTES) begin
         failures++;
         $display("FAIL start_stream_intact: %0d bad first %0d n=%0d, required 0 and %0d", nb, first_bad, got_n, PK_BYTES);
      end
      checks++;
      if (done_cnt != 1 || timed_out) begin
         failures++;
         $display("FAIL start_single_done: done=%0d timeout=%0d, required 1 0", done_cnt, timed_out);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL start_in_done_ignored: valid=%b busy=%b done=%b, required 0 0 0", m_tvalid, busy, done);
      end
      rand_model(); build_exp(); apply_inputs();
      start_stream("restart");
      collect(100, -1, 0, 0);
      nb = count_bad();
      checks++;
      if (nb != 0 || got_n != PK_BYTES || done_cnt != 1) begin
         failures++;
         $display("FAIL restart_stream: %0d bad first %0d n=%0d done=%0d, required 0 %0d 1",
                  nb, first_bad, got_n, done_cnt, PK_BYTES);
      end
   endtask

   task automatic test_midstream_reset();
      int nb, dseen, vseen;
      rand_model(); build_exp(); apply_inputs();
      start_stream("abort");
      collect(60, 500, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00) begin
         failures++;
         $display("FAIL abort_async: valid=%b busy=%b done=%b last=%b data=%h, required 0 0 0 0 00",
                  m_tvalid, busy, done, m_tlast, m_tdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dseen = 0; vseen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done !== 1'b0) dseen++;
         if (m_tvalid !== 1'b0) vseen++;
      end
      checks++;
      if (dseen != 0 || vseen != 0) begin
         failures++;
         $display("FAIL abort_no_done: done cycles=%0d valid cycles=%0d, required 0 0", dseen, vseen);
      end
      rand_model(); build_exp(); apply_inputs();
      start_stream("abort_restart");
      collect(100, -1, 0, 0);
      nb = count_bad();
      checks++;
      if (nb != 0 || got_n != PK_BYTES || done_cnt != 1 || tlast_bad != 0) begin
         failures++;
         $display("FAIL abort_restart_stream: %0d bad first %0d n=%0d done=%0d, required 0 %0d 1",
                  nb, first_bad, got_n, done_cnt, PK_BYTES);
      end
   endtask

   initial begin
      test_reset();
      test_packing();
      test_rho_tail();
      test_backpressure();
      test_start_handling();
      test_midstream_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
